// File: rtl/inst_queue_n_pkg.sv
// Shared types and helpers for the N-wide fetch-to-decode instruction queue.
package inst_queue_n_pkg;

  localparam int unsigned IQ_XLEN  = 32;
  localparam int unsigned IQ_LANES = 2;
  // Widest valid vector lead_ones() can scan.
  localparam int unsigned LEAD_MAX = 32;

  typedef struct packed {
    logic [IQ_XLEN-1:0] pc;
    logic [IQ_XLEN-1:0] instr;
  } inst_pc_t;

  typedef inst_pc_t [IQ_LANES-1:0] inst_pc_lanes_t;

  // Length of the run of set bits starting at bit 0 (the usable push lanes).
  function automatic int unsigned lead_ones(input logic [LEAD_MAX-1:0] vec);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < LEAD_MAX; i++) begin
      run = run & vec[i];
      if (run) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_queue_n_mem.sv
// Circular storage for the instruction queue: LANES write ports starting at
// the write pointer, LANES read ports starting at the read pointer. Each entry
// is {pc, instr}. Storage is never reset; occupancy tracking lives in the top.
module inst_queue_n_mem #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned EW   = 2 * XLEN
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      wr_en_i,
  input  logic [AW-1:0]         wr_ptr_i,
  input  logic [LANES*EW-1:0]   wr_data_i,
  input  logic [AW-1:0]         rd_ptr_i,
  output logic [LANES*EW-1:0]   rd_data_o
);

  logic [EW-1:0] mem_q [DEPTH];

  // Write each enabled lane into consecutive slots; pointer math wraps at DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en_i[i]) mem_q[wr_ptr_i + AW'(i)] <= wr_data_i[i*EW +: EW];
    end
  end

  // First-word-fall-through read: lane i shows the entry at rd_ptr + i.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_data_o[i*EW +: EW] = mem_q[rd_ptr_i + AW'(i)];
    end
  end

endmodule

// File: rtl/inst_queue_n.sv
// N-wide instruction queue between fetch and decode. Fetch pushes up to LANES
// {pc,instr} pairs per cycle, decode pops up to LANES in program order, and a
// flush (redirect) empties it. Output falls through combinationally from
// storage; a pushed entry becomes visible the cycle after it is written.
//
// Handshake: a push is accepted only when in_ready=1, and then every lane in
// the leading contiguous run of in_valid is written. in_ready depends only on
// the registered count, so a same-cycle pop never creates room. Decode states
// how many entries it consumes through out_take; asking for more than are
// present pops what exists and sets the sticky take_err.
module inst_queue_n
  import inst_queue_n_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH+1),
  localparam int unsigned TW   = $clog2(LANES+1),
  localparam int unsigned EW   = 2 * XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*XLEN-1:0] in_pc,
  input  logic [LANES*XLEN-1:0] in_instr,
  output logic                  in_ready,
  output logic [LANES-1:0]      out_valid,
  output logic [LANES*XLEN-1:0] out_pc,
  output logic [LANES*XLEN-1:0] out_instr,
  input  logic [TW-1:0]         out_take,
  output logic [CW-1:0]         count,
  output logic                  take_err
);

  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                take_err_q, take_err_d;

  logic [CW-1:0]       lead_cnt;
  logic [LANES-1:0]    contig_mask;
  logic [CW-1:0]       n_push;
  logic [CW-1:0]       n_pop;
  logic [CW-1:0]       take_ext;
  logic                take_over;
  logic [LANES-1:0]    wr_en;
  logic [LANES*EW-1:0] wr_data;
  logic [LANES*EW-1:0] rd_data;

  // Room for a full-width push, judged on the registered occupancy only.
  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(LANES);

  // Push sizing: only the contiguous run from lane 0 is ever written.
  always_comb begin
    lead_cnt    = CW'(lead_ones(LEAD_MAX'(in_valid)));
    contig_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      contig_mask[i] = CW'(i) < lead_cnt;
    end
    n_push = '0;
    if (in_ready && !flush) n_push = lead_cnt;
  end

  // Pop sizing: clamp the requested take to what is present and flag overreach.
  always_comb begin
    take_ext  = CW'(out_take);
    take_over = take_ext > count_q;
    n_pop     = '0;
    if (!flush) n_pop = take_over ? count_q : take_ext;
  end

  // Lane write enables and {pc,instr} packing toward storage.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_en[i]              = CW'(i) < n_push;
      wr_data[i*EW +: EW]   = {in_pc[i*XLEN +: XLEN], in_instr[i*XLEN +: XLEN]};
    end
  end

  // Next-state for pointers, occupancy and the sticky error.
  always_comb begin
    head_d     = head_q + AW'(n_pop);
    tail_d     = tail_q + AW'(n_push);
    count_d    = count_q + n_push - n_pop;
    take_err_d = take_err_q | (!flush && take_over);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Queue control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      take_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      take_err_q <= take_err_d;
    end
  end

  inst_queue_n_mem #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (tail_q),
    .wr_data_i (wr_data),
    .rd_ptr_i  (head_q),
    .rd_data_o (rd_data)
  );

  // Output lanes: lane i is valid when at least i+1 entries are held.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_instr = '0;
    for (int i = 0; i < LANES; i++) begin
      out_valid[i]              = count_q > CW'(i);
      out_pc[i*XLEN +: XLEN]    = rd_data[i*EW + XLEN +: XLEN];
      out_instr[i*XLEN +: XLEN] = rd_data[i*EW +: XLEN];
    end
  end

  assign count    = count_q;
  assign take_err = take_err_q;

`ifndef SYNTHESIS
  // Fetch must present valid lanes packed from lane 0; occupancy stays bounded.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (in_valid == contig_mask)
        else $error("inst_queue_n: non-contiguous in_valid %b", in_valid);
      assert (count_q <= CW'(DEPTH))
        else $error("inst_queue_n: count %0d above depth", count_q);
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue_n.sv
// Bench for inst_queue_n (LANES=2, DEPTH=8, XLEN=32).
module tb_inst_queue_n;
  import inst_queue_n_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        flush    = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_pc    = '0;
  logic [63:0] in_instr = '0;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_instr;
  logic [1:0]  out_take = '0;
  logic [3:0]  count;
  logic        take_err;

  always #5 clk = ~clk;

  inst_queue_n #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_take  (out_take),
    .count     (count),
    .take_err  (take_err)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  int          m_count  = 0;
  logic        m_err    = 1'b0;
  logic [31:0] next_pc  = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc * 32'd3 + 32'h1357_0001;
  endfunction

  // ---------------- driver ----------------
  // One clock: drive inputs, compare current outputs against the model,
  // advance the model across the edge, then check the sticky error.
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] take, input logic fl);
    int       npush;
    int       npop;
    logic     ready;
    logic     over;
    inst_pc_t e;
    in_valid = v;
    out_take = take;
    flush    = fl;
    for (int i = 0; i < LANES; i++) begin
      in_pc[i*32 +: 32]    = next_pc + 32'(4*i);
      in_instr[i*32 +: 32] = instr_of(next_pc + 32'(4*i));
    end
    #1;
    ready = (DEPTH - m_count) >= LANES;
    npush = (fl || !ready) ? 0 : (v == 2'b11 ? 2 : (v == 2'b01 ? 1 : 0));
    over  = int'(take) > m_count;
    npop  = fl ? 0 : (over ? m_count : int'(take));
    check_eq("in_ready", 64'(in_ready), 64'(ready));
    check_eq("count", 64'(count), 64'(m_count));
    for (int i = 0; i < LANES; i++) begin
      check_eq("out_valid", 64'(out_valid[i]), 64'(i < m_count));
    end
    for (int i = 0; i < npop; i++) begin
      e = exp_q[i];
      check_eq("out_pc", 64'(out_pc[i*32 +: 32]), 64'(e.pc));
      check_eq("out_instr", 64'(out_instr[i*32 +: 32]), 64'(e.instr));
    end
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      repeat (npop) void'(exp_q.pop_front());
      for (int i = 0; i < npush; i++) begin
        e.pc    = next_pc + 32'(4*i);
        e.instr = instr_of(e.pc);
        exp_q.push_back(e);
      end
      m_count = m_count + npush - npop;
      m_err   = m_err | over;
      next_pc = next_pc + 32'(4*npush);
    end
    #1;
    check_eq("take_err", 64'(take_err), 64'(m_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rv;
    logic [1:0] rt;
    logic       rf;

    // Reset held
    #12;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_take_err", 64'(take_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_count", 64'(count), 64'd0);
    check_eq("rel_out_valid", 64'(out_valid), 64'd0);
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);

    // Fill to full; the fifth push must be refused
    repeat (4) drive_cycle(2'b11, 2'd0, 1'b0);
    check_eq("fill_count", 64'(count), 64'd8);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    drive_cycle(2'b11, 2'd0, 1'b0);
    check_eq("fill_hold_count", 64'(count), 64'd8);
    check_eq("fill_pc0", 64'(out_pc[31:0]), 64'h0);
    check_eq("fill_pc1", 64'(out_pc[63:32]), 64'h4);

    // Steady push-2/take-2 across pointer wrap
    drive_cycle(2'b00, 2'd2, 1'b0);
    repeat (20) drive_cycle(2'b11, 2'd2, 1'b0);
    check_eq("steady_count", 64'(count), 64'd6);
    repeat (3) drive_cycle(2'b00, 2'd2, 1'b0);
    check_eq("drain_count", 64'(count), 64'd0);

    // Partial push, then over-take
    drive_cycle(2'b01, 2'd0, 1'b0);
    check_eq("partial_count", 64'(count), 64'd1);
    drive_cycle(2'b00, 2'd2, 1'b0);
    check_eq("overtake_count", 64'(count), 64'd0);
    check_eq("overtake_err", 64'(take_err), 64'd1);

    // Flush with a push and take in the same cycle
    drive_cycle(2'b11, 2'd0, 1'b0);
    drive_cycle(2'b11, 2'd0, 1'b0);
    drive_cycle(2'b01, 2'd0, 1'b0);
    check_eq("preflush_count", 64'(count), 64'd5);
    drive_cycle(2'b11, 2'd2, 1'b1);
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_take_err", 64'(take_err), 64'd1);

    // Random traffic
    repeat (60) begin
      rv = 2'($urandom_range(0, 2));
      rv = (rv == 2'd2) ? 2'b11 : rv;
      rt = 2'($urandom_range(0, 2));
      rf = ($urandom_range(0, 15) == 0);
      drive_cycle(rv, rt, rf);
    end

    // Asynchronous reset between edges with six entries held
    drive_cycle(2'b00, 2'd0, 1'b1);
    repeat (3) drive_cycle(2'b11, 2'd0, 1'b0);
    check_eq("pre_arst_count", 64'(count), 64'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_take_err", 64'(take_err), 64'd0);
    exp_q.delete();
    m_count = 0;
    m_err   = 1'b0;
    in_valid = '0;
    out_take = '0;
    flush    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(2'b11, 2'd0, 1'b0);
    drive_cycle(2'b01, 2'd2, 1'b0);
    drive_cycle(2'b00, 2'd1, 1'b0);
    drive_cycle(2'b00, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
